// File: rtl/drop_unit_pkg.sv
// drop_unit_pkg
//   Shared definitions for the multi-drop response unit.
//   - drop_cnt_width(): number of bits needed to hold 0..max_drops.
//   - c_mode_pass / c_mode_drop: decoded operating mode, exposed as a named
//     signal inside the top so it is easy to spot on a waveform.
package drop_unit_pkg;

  localparam logic c_mode_pass = 1'b0;
  localparam logic c_mode_drop = 1'b1;

  function automatic int drop_cnt_width(input int max_drops);
    return $clog2(max_drops + 1);
  endfunction

endpackage

// File: rtl/drop_unit_pipe_reg.sv
// drop_unit_pipe_reg
//   One-entry val/rdy pipe register. Holds a single message and can accept a
//   new one in the same cycle the held one is drained (full throughput).
// Ports:
//   clk        clock
//   reset      asynchronous active-low reset; empties the register
//   in_val_i   upstream message valid
//   in_rdy_o   register can take a message (empty, or draining this cycle)
//   in_msg_i   upstream message
//   out_val_o  register holds a message
//   out_rdy_i  downstream ready
//   out_msg_o  held message
module drop_unit_pipe_reg #(
  parameter int p_msg_nbits = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_val_i,
  output logic                   in_rdy_o,
  input  logic [p_msg_nbits-1:0] in_msg_i,
  output logic                   out_val_o,
  input  logic                   out_rdy_i,
  output logic [p_msg_nbits-1:0] out_msg_o
);

  logic                   full_q, full_d;
  logic [p_msg_nbits-1:0] msg_q, msg_d;
  logic                   enq, deq;

  assign in_rdy_o  = !full_q || out_rdy_i;
  assign enq       = in_val_i && in_rdy_o;
  assign deq       = full_q && out_rdy_i;
  assign out_val_o = full_q;
  assign out_msg_o = msg_q;

  always_comb begin
    full_d = full_q;
    msg_d  = msg_q;
    if (enq) begin
      full_d = 1'b1;
      msg_d  = in_msg_i;
    end else if (deq) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q <= 1'b0;
      msg_q  <= '0;
    end else begin
      full_q <= full_d;
      msg_q  <= msg_d;
    end
  end

endmodule

// File: rtl/drop_unit_multi.sv
// drop_unit_multi
//   Memory-response filter that silently consumes one response per squashed
//   in-flight request. Up to p_max_drops squashes may be outstanding; the
//   corresponding responses are eaten in arrival order. Optionally registers
//   the forwarded stream to cut the rdy/val combinational path.
// Ports:
//   clk          clock
//   reset        asynchronous active-low reset
//   drop         one pulse per squashed request
//   istream_*    incoming responses from memory (val/rdy)
//   ostream_*    forwarded responses to the pipeline (val/rdy)
//   pending      registered count of responses still to be dropped
//   overflow     sticky: a drop arrived while the counter was saturated
module drop_unit_multi
  import drop_unit_pkg::*;
#(
  parameter int p_msg_nbits = 1,
  parameter int p_max_drops = 3,
  parameter int p_pipe_en   = 0
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       drop,
  input  logic [p_msg_nbits-1:0]                     istream_msg,
  input  logic                                       istream_val,
  output logic                                       istream_rdy,
  output logic [p_msg_nbits-1:0]                     ostream_msg,
  output logic                                       ostream_val,
  input  logic                                       ostream_rdy,
  output logic [drop_cnt_width(p_max_drops)-1:0]     pending,
  output logic                                       overflow
);

  localparam int c_cw = drop_cnt_width(p_max_drops);
  localparam logic [c_cw:0] c_max = (c_cw + 1)'(p_max_drops);

  logic [c_cw-1:0] cnt_q, cnt_d;
  logic            overflow_q, overflow_d;
  logic [c_cw:0]   cnt_eff;
  logic [c_cw:0]   cnt_net;
  logic            mode;
  logic            drop_mode;
  logic            consume;
  logic            sat;
  logic            pass_rdy;

  // The same-cycle drop already counts, so a response arriving alongside the
  // first squash is the one that gets eaten.
  assign cnt_eff   = {1'b0, cnt_q} + {{c_cw{1'b0}}, drop};
  assign mode      = (cnt_eff != '0) ? c_mode_drop : c_mode_pass;
  assign drop_mode = (mode == c_mode_drop);
  assign consume   = istream_val && drop_mode;

  // Saturation is judged on the net count, so drop+consume at the limit is
  // not an overflow.
  assign cnt_net = cnt_eff - {{c_cw{1'b0}}, consume};
  assign sat     = (cnt_net > c_max);

  always_comb begin
    cnt_d      = cnt_net[c_cw-1:0];
    overflow_d = overflow_q;
    if (sat) begin
      cnt_d      = c_max[c_cw-1:0];
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign pending  = cnt_q;
  assign overflow = overflow_q;

  // In drop mode the response is always taken; otherwise readiness comes
  // from whatever sits downstream.
  assign istream_rdy = reset && (drop_mode || pass_rdy);

  generate
    if (p_pipe_en != 0) begin : g_pipe
      logic pipe_in_val;

      // Squashed responses never enter the register; a message already held
      // belongs to an older request and drains normally.
      assign pipe_in_val = istream_val && !drop_mode;

      drop_unit_pipe_reg #(
        .p_msg_nbits (p_msg_nbits)
      ) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_val_i  (pipe_in_val),
        .in_rdy_o  (pass_rdy),
        .in_msg_i  (istream_msg),
        .out_val_o (ostream_val),
        .out_rdy_i (ostream_rdy),
        .out_msg_o (ostream_msg)
      );
    end else begin : g_bypass
      // A stalled response vanishes from ostream the moment a drop arrives.
      assign pass_rdy    = ostream_rdy;
      assign ostream_val = reset && istream_val && !drop_mode;
      assign ostream_msg = istream_msg;
    end
  endgenerate

endmodule

// File: tb/tb_drop_unit_multi.sv
module tb_drop_unit_multi;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: combinational pass-through
  logic       rst0_n;
  logic       drop0;
  logic [7:0] istream_msg0;
  logic       istream_val0;
  logic       istream_rdy0;
  logic [7:0] ostream_msg0;
  logic       ostream_val0;
  logic       ostream_rdy0;
  logic [1:0] pending0;
  logic       overflow0;

  // DUT 1: output pipe register
  logic       rst1_n;
  logic       drop1;
  logic [7:0] istream_msg1;
  logic       istream_val1;
  logic       istream_rdy1;
  logic [7:0] ostream_msg1;
  logic       ostream_val1;
  logic       ostream_rdy1;
  logic [1:0] pending1;
  logic       overflow1;

  int n_pass  = 0;
  int n_total = 0;

  drop_unit_multi #(.p_msg_nbits(8), .p_max_drops(3), .p_pipe_en(0)) u_dut0 (
    .clk         (clk),
    .reset       (rst0_n),
    .drop        (drop0),
    .istream_msg (istream_msg0),
    .istream_val (istream_val0),
    .istream_rdy (istream_rdy0),
    .ostream_msg (ostream_msg0),
    .ostream_val (ostream_val0),
    .ostream_rdy (ostream_rdy0),
    .pending     (pending0),
    .overflow    (overflow0)
  );

  drop_unit_multi #(.p_msg_nbits(8), .p_max_drops(3), .p_pipe_en(1)) u_dut1 (
    .clk         (clk),
    .reset       (rst1_n),
    .drop        (drop1),
    .istream_msg (istream_msg1),
    .istream_val (istream_val1),
    .istream_rdy (istream_rdy1),
    .ostream_msg (ostream_msg1),
    .ostream_val (ostream_val1),
    .ostream_rdy (ostream_rdy1),
    .pending     (pending1),
    .overflow    (overflow1)
  );

  // Inputs change 1 time unit after a rising edge; outputs sampled 4 later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst0_n = 1'b0; rst1_n = 1'b0;
    drop0 = 1'b0; drop1 = 1'b0;
    istream_val0 = 1'b1; istream_msg0 = 8'h99; ostream_rdy0 = 1'b1;
    istream_val1 = 1'b1; istream_msg1 = 8'h99; ostream_rdy1 = 1'b1;
    step(); step();
    #4;
    n_total++; if (pending0 !== 2'd0) $display("FAIL reset_pending0 got=%0d exp=0", pending0); else n_pass++;
    n_total++; if (overflow0 !== 1'b0) $display("FAIL reset_overflow0 got=%b exp=0", overflow0); else n_pass++;
    n_total++; if (istream_rdy0 !== 1'b0) $display("FAIL reset_irdy0 got=%b exp=0", istream_rdy0); else n_pass++;
    n_total++; if (ostream_val0 !== 1'b0) $display("FAIL reset_oval0 got=%b exp=0", ostream_val0); else n_pass++;
    n_total++; if (istream_rdy1 !== 1'b0) $display("FAIL reset_irdy1 got=%b exp=0", istream_rdy1); else n_pass++;
    n_total++; if (ostream_val1 !== 1'b0) $display("FAIL reset_oval1 got=%b exp=0", ostream_val1); else n_pass++;
    $display("reset: pending0=%0d overflow0=%b irdy0=%b oval0=%b oval1=%b", pending0, overflow0, istream_rdy0, ostream_val0, ostream_val1);
    istream_val0 = 1'b0; istream_val1 = 1'b0;
    step();
    rst0_n = 1'b1; rst1_n = 1'b1;
    step();
  endtask

  task automatic test_pass();
    logic [7:0] vec [3];
    vec[0] = 8'h11; vec[1] = 8'h22; vec[2] = 8'h33;
    ostream_rdy0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      istream_val0 = 1'b1; istream_msg0 = vec[i];
      #4;
      n_total++; if (ostream_val0 !== 1'b1) $display("FAIL pass_oval got=%b exp=1", ostream_val0); else n_pass++;
      n_total++; if (ostream_msg0 !== vec[i]) $display("FAIL pass_omsg got=%h exp=%h", ostream_msg0, vec[i]); else n_pass++;
      n_total++; if (istream_rdy0 !== 1'b1) $display("FAIL pass_irdy got=%b exp=1", istream_rdy0); else n_pass++;
      n_total++; if (pending0 !== 2'd0) $display("FAIL pass_pending got=%0d exp=0", pending0); else n_pass++;
      $display("pass: in=%h out=%h oval=%b pending=%0d", vec[i], ostream_msg0, ostream_val0, pending0);
      step();
    end
    istream_val0 = 1'b0;
  endtask

  task automatic test_drop_same_cycle();
    drop0 = 1'b1; istream_val0 = 1'b1; istream_msg0 = 8'hAA;
    #4;
    n_total++; if (istream_rdy0 !== 1'b1) $display("FAIL same_irdy got=%b exp=1", istream_rdy0); else n_pass++;
    n_total++; if (ostream_val0 !== 1'b0) $display("FAIL same_oval got=%b exp=0", ostream_val0); else n_pass++;
    $display("same-cycle drop: msg=AA irdy=%b oval=%b", istream_rdy0, ostream_val0);
    step();
    drop0 = 1'b0; istream_msg0 = 8'hBB;
    #4;
    n_total++; if (ostream_val0 !== 1'b1) $display("FAIL same_next_oval got=%b exp=1", ostream_val0); else n_pass++;
    n_total++; if (ostream_msg0 !== 8'hBB) $display("FAIL same_next_omsg got=%h exp=bb", ostream_msg0); else n_pass++;
    n_total++; if (pending0 !== 2'd0) $display("FAIL same_pending got=%0d exp=0", pending0); else n_pass++;
    $display("same-cycle drop: next msg=%h oval=%b pending=%0d", ostream_msg0, ostream_val0, pending0);
    step();
    istream_val0 = 1'b0;
  endtask

  task automatic test_multi_drop();
    logic [1:0] exp_p;
    istream_val0 = 1'b0; ostream_rdy0 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drop0 = 1'b1;
      step();
      exp_p = 2'(i);
      #4;
      n_total++; if (pending0 !== exp_p) $display("FAIL multi_fill_pending got=%0d exp=%0d", pending0, exp_p); else n_pass++;
      $display("multi drop pulse %0d: pending=%0d", i, pending0);
    end
    drop0 = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      istream_val0 = 1'b1; istream_msg0 = 8'(i + 1);
      exp_p = 2'(3 - i);
      #4;
      n_total++; if (pending0 !== exp_p) $display("FAIL multi_drain_pending got=%0d exp=%0d", pending0, exp_p); else n_pass++;
      if (i < 3) begin
        n_total++; if (ostream_val0 !== 1'b0) $display("FAIL multi_consume_oval got=%b exp=0", ostream_val0); else n_pass++;
        n_total++; if (istream_rdy0 !== 1'b1) $display("FAIL multi_consume_irdy got=%b exp=1", istream_rdy0); else n_pass++;
      end else begin
        n_total++; if (ostream_val0 !== 1'b1) $display("FAIL multi_fwd_oval got=%b exp=1", ostream_val0); else n_pass++;
        n_total++; if (ostream_msg0 !== 8'h04) $display("FAIL multi_fwd_omsg got=%h exp=04", ostream_msg0); else n_pass++;
      end
      $display("multi drain: msg=%h pending=%0d oval=%b", istream_msg0, pending0, ostream_val0);
      step();
    end
    istream_val0 = 1'b0;
  endtask

  task automatic test_overflow();
    logic [1:0] exp_p;
    logic       exp_o;
    istream_val0 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drop0 = 1'b1;
      step();
      exp_p = (k >= 3) ? 2'd3 : 2'(k);
      exp_o = (k >= 4);
      #4;
      n_total++; if (pending0 !== exp_p) $display("FAIL ovf_pending got=%0d exp=%0d", pending0, exp_p); else n_pass++;
      n_total++; if (overflow0 !== exp_o) $display("FAIL ovf_flag got=%b exp=%b", overflow0, exp_o); else n_pass++;
      $display("overflow pulse %0d: pending=%0d overflow=%b", k, pending0, overflow0);
    end
    drop0 = 1'b0;
    step();
    #4;
    n_total++; if (overflow0 !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", overflow0); else n_pass++;
    rst0_n = 1'b0;
    #1;
    n_total++; if (pending0 !== 2'd0) $display("FAIL ovf_rst_pending got=%0d exp=0", pending0); else n_pass++;
    n_total++; if (overflow0 !== 1'b0) $display("FAIL ovf_rst_flag got=%b exp=0", overflow0); else n_pass++;
    $display("overflow reset: pending=%0d overflow=%b", pending0, overflow0);
    step();
    rst0_n = 1'b1;
    step();
    // Fill to the limit, then drop+arrival together: net unchanged, no overflow.
    for (int k = 0; k < 3; k++) begin
      drop0 = 1'b1;
      step();
    end
    istream_val0 = 1'b1; istream_msg0 = 8'h77;
    step();
    drop0 = 1'b0; istream_val0 = 1'b0;
    #4;
    n_total++; if (pending0 !== 2'd3) $display("FAIL sat_net_pending got=%0d exp=3", pending0); else n_pass++;
    n_total++; if (overflow0 !== 1'b0) $display("FAIL sat_net_flag got=%b exp=0", overflow0); else n_pass++;
    $display("drop+arrival at limit: pending=%0d overflow=%b", pending0, overflow0);
    istream_val0 = 1'b1;
    for (int k = 0; k < 3; k++) step();
    istream_val0 = 1'b0;
    #4;
    n_total++; if (pending0 !== 2'd0) $display("FAIL sat_drain_pending got=%0d exp=0", pending0); else n_pass++;
    step();
  endtask

  task automatic test_pipe_hold();
    ostream_rdy1 = 1'b0; drop1 = 1'b0;
    istream_val1 = 1'b1; istream_msg1 = 8'h55;
    #4;
    n_total++; if (istream_rdy1 !== 1'b1) $display("FAIL hold_irdy_empty got=%b exp=1", istream_rdy1); else n_pass++;
    n_total++; if (ostream_val1 !== 1'b0) $display("FAIL hold_latency got=%b exp=0", ostream_val1); else n_pass++;
    step();
    istream_val1 = 1'b0; drop1 = 1'b1;
    #4;
    n_total++; if (ostream_val1 !== 1'b1) $display("FAIL hold_oval_on_drop got=%b exp=1", ostream_val1); else n_pass++;
    n_total++; if (ostream_msg1 !== 8'h55) $display("FAIL hold_omsg_on_drop got=%h exp=55", ostream_msg1); else n_pass++;
    step();
    drop1 = 1'b0; istream_val1 = 1'b1; istream_msg1 = 8'h66;
    #4;
    n_total++; if (pending1 !== 2'd1) $display("FAIL hold_pending1 got=%0d exp=1", pending1); else n_pass++;
    n_total++; if (istream_rdy1 !== 1'b1) $display("FAIL hold_irdy_drop got=%b exp=1", istream_rdy1); else n_pass++;
    step();
    istream_val1 = 1'b0;
    #4;
    n_total++; if (pending1 !== 2'd0) $display("FAIL hold_pending0 got=%0d exp=0", pending1); else n_pass++;
    n_total++; if (ostream_msg1 !== 8'h55) $display("FAIL hold_still55 got=%h exp=55", ostream_msg1); else n_pass++;
    step();
    ostream_rdy1 = 1'b1;
    #4;
    n_total++; if (ostream_val1 !== 1'b1 || ostream_msg1 !== 8'h55) $display("FAIL hold_deliver got=%b/%h exp=1/55", ostream_val1, ostream_msg1); else n_pass++;
    $display("pipe hold: delivered msg=%h pending=%0d", ostream_msg1, pending1);
    step();
    #4;
    n_total++; if (ostream_val1 !== 1'b0) $display("FAIL hold_no_66 got=%b exp=0", ostream_val1); else n_pass++;
    step();
  endtask

  task automatic test_pipe_stream();
    int  sent = 0;
    int  recv = 0;
    logic acc;
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      ostream_rdy1 = (cyc % 2 == 0);
      istream_val1 = (sent < 8);
      istream_msg1 = 8'h10 + 8'(sent);
      #4;
      if (cyc == 0) begin
        n_total++; if (ostream_val1 !== 1'b0) $display("FAIL stream_latency got=%b exp=0", ostream_val1); else n_pass++;
      end
      acc = istream_val1 && istream_rdy1;
      if (ostream_val1 && ostream_rdy1) begin
        n_total++;
        if (ostream_msg1 !== 8'h10 + 8'(recv)) $display("FAIL stream_order got=%h exp=%h", ostream_msg1, 8'h10 + 8'(recv));
        else n_pass++;
        $display("stream: delivered %h at cycle %0d", ostream_msg1, cyc);
        recv++;
      end
      step();
      if (acc) sent++;
    end
    istream_val1 = 1'b0;
    #4;
    n_total++; if (recv != 8) $display("FAIL stream_count got=%0d exp=8", recv); else n_pass++;
    n_total++; if (ostream_val1 !== 1'b0) $display("FAIL stream_dup got=%b exp=0", ostream_val1); else n_pass++;
    step();
  endtask

  task automatic test_pipe_reset_mid();
    ostream_rdy1 = 1'b0;
    istream_val1 = 1'b1; istream_msg1 = 8'h20;
    step();
    istream_msg1 = 8'h21;
    #4;
    n_total++; if (ostream_val1 !== 1'b1) $display("FAIL midrst_full got=%b exp=1", ostream_val1); else n_pass++;
    rst1_n = 1'b0;
    #1;
    n_total++; if (ostream_val1 !== 1'b0) $display("FAIL midrst_oval got=%b exp=0", ostream_val1); else n_pass++;
    n_total++; if (istream_rdy1 !== 1'b0) $display("FAIL midrst_irdy got=%b exp=0", istream_rdy1); else n_pass++;
    $display("mid-stream reset: oval=%b irdy=%b", ostream_val1, istream_rdy1);
    step();
    rst1_n = 1'b1; istream_val1 = 1'b0;
    #4;
    n_total++; if (ostream_val1 !== 1'b0) $display("FAIL midrst_empty got=%b exp=0", ostream_val1); else n_pass++;
    step();
    ostream_rdy1 = 1'b1; istream_val1 = 1'b1; istream_msg1 = 8'h30;
    #4;
    n_total++; if (ostream_val1 !== 1'b0) $display("FAIL postrst_latency got=%b exp=0", ostream_val1); else n_pass++;
    step();
    istream_val1 = 1'b0;
    #4;
    n_total++; if (ostream_val1 !== 1'b1 || ostream_msg1 !== 8'h30) $display("FAIL postrst_msg got=%b/%h exp=1/30", ostream_val1, ostream_msg1); else n_pass++;
    $display("after reset: delivered msg=%h", ostream_msg1);
    step();
  endtask

  initial begin
    test_reset();
    test_pass();
    test_drop_same_cycle();
    test_multi_drop();
    test_overflow();
    test_pipe_hold();
    test_pipe_stream();
    test_pipe_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
